// File: rtl/instruc_loader_if.sv
// Byte-stream input and instruction-memory write-port bundle of the loader.
// slave is the loader side; master is the feeder/observer side.
interface instruc_loader_if #(
    parameter int SIZE_ADDR_PC = 32,
    parameter int SIZE_BYTE    = 8
);
    logic                    i_start_load;
    logic [SIZE_BYTE-1:0]    i_rx_data;
    logic                    i_rx_valid;
    logic [SIZE_ADDR_PC-1:0] o_instruction_address;
    logic [SIZE_ADDR_PC-1:0] o_instruction;
    logic                    o_flag_write_intruc;
    logic                    o_busy;
    logic                    o_load_done;
    logic [SIZE_ADDR_PC-1:0] o_word_count;

    modport slave (
        input  i_start_load, i_rx_data, i_rx_valid,
        output o_instruction_address, o_instruction, o_flag_write_intruc,
               o_busy, o_load_done, o_word_count
    );

    modport master (
        output i_start_load, i_rx_data, i_rx_valid,
        input  o_instruction_address, o_instruction, o_flag_write_intruc,
               o_busy, o_load_done, o_word_count
    );
endinterface

// File: rtl/instruc_loader.sv
// Assembles big-endian byte groups into instruction words and writes them to
// instruction memory until the HALT word is written or memory is full.
module instruc_loader #(
    parameter int                SIZE_ADDR_PC = 32,
    parameter int                TOTAL_SIZE   = 256,
    parameter logic [31:0]       HALT_WORD    = 32'hFFFF_FFFF,
    parameter int                SIZE_BYTE    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    instruc_loader_if.slave       ldr_bus
);
    localparam int BYTES_PER_WORD = SIZE_ADDR_PC / SIZE_BYTE;
    localparam int BCW            = $clog2(BYTES_PER_WORD);
    localparam logic [BCW-1:0]          LAST_BYTE = BCW'(BYTES_PER_WORD - 1);
    localparam logic [SIZE_ADDR_PC-1:0] LAST_ADDR = SIZE_ADDR_PC'(TOTAL_SIZE - 1);
    localparam logic [SIZE_ADDR_PC-1:0] HALT_W    = SIZE_ADDR_PC'(HALT_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [SIZE_ADDR_PC-1:0] shift_q, shift_d;
    logic [BCW-1:0]          byte_cnt_q, byte_cnt_d;
    logic [SIZE_ADDR_PC-1:0] addr_q, addr_d;
    logic [SIZE_ADDR_PC-1:0] word_count_q, word_count_d;
    logic [SIZE_ADDR_PC-1:0] instr_q, instr_d;
    logic [SIZE_ADDR_PC-1:0] instr_addr_q, instr_addr_d;
    logic                    strobe_q, strobe_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [SIZE_ADDR_PC-1:0] assembled_s;

    assign assembled_s = {shift_q[SIZE_ADDR_PC-SIZE_BYTE-1:0], ldr_bus.i_rx_data};

    // Next-state and datapath update for the load sequencer
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        instr_d      = instr_q;
        instr_addr_d = instr_addr_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (ldr_bus.i_start_load) begin
                    addr_d       = '0;
                    word_count_d = '0;
                    byte_cnt_d   = '0;
                    shift_d      = '0;
                    state_d      = ST_RECV;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RECV: begin
                if (ldr_bus.i_rx_valid) begin
                    shift_d = assembled_s;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d   = '0;
                        instr_d      = assembled_s;
                        instr_addr_d = addr_q;
                        state_d      = ST_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_WRITE: begin
                word_count_d = word_count_q + SIZE_ADDR_PC'(1);
                if ((instr_q == HALT_W) || (addr_q == LAST_ADDR)) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + SIZE_ADDR_PC'(1);
                    state_d = ST_RECV;
                    // A byte arriving during the write cycle opens the next word
                    if (ldr_bus.i_rx_valid) begin
                        shift_d    = assembled_s;
                        byte_cnt_d = BCW'(1);
                    end else begin
                        byte_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered copies of the current state
    always_comb begin
        strobe_d = (state_q == ST_WRITE);
        busy_d   = (state_q == ST_RECV) || (state_q == ST_WRITE);
        done_d   = (state_q == ST_DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            addr_q       <= '0;
            word_count_q <= '0;
            instr_q      <= '0;
            instr_addr_q <= '0;
            strobe_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            instr_q      <= instr_d;
            instr_addr_q <= instr_addr_d;
            strobe_q     <= strobe_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign ldr_bus.o_instruction_address = instr_addr_q;
    assign ldr_bus.o_instruction         = instr_q;
    assign ldr_bus.o_flag_write_intruc   = strobe_q;
    assign ldr_bus.o_busy                = busy_q;
    assign ldr_bus.o_load_done           = done_q;
    assign ldr_bus.o_word_count          = word_count_q;
endmodule

// File: tb/tb_instruc_loader.sv
// Scoreboard bench for instruc_loader: a byte-level reference model predicts
// every memory write, and a negedge monitor checks each strobe against it.
module tb_instruc_loader;
    localparam int          TOTAL = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] count;
    } wr_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    wr_t        exp_q[$];
    logic [7:0] m_bytes[$];
    bit         m_loading;
    int         m_addr;
    int         m_count;
    logic       strobe_prev;

    instruc_loader_if #(.SIZE_ADDR_PC(32), .SIZE_BYTE(8)) bus ();

    instruc_loader #(
        .SIZE_ADDR_PC(32),
        .TOTAL_SIZE  (TOTAL),
        .HALT_WORD   (HALT),
        .SIZE_BYTE   (8)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .ldr_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one call per clock with the inputs the DUT samples
    task automatic model_step(input logic st, input logic v, input logic [7:0] d);
        logic [31:0] w;
        wr_t e;
        if (st && !m_loading) begin
            m_loading = 1'b1;
            m_addr    = 0;
            m_count   = 0;
            m_bytes.delete();
        end else if (v && m_loading) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
                w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_bytes.delete();
                m_count++;
                e.addr  = m_addr;
                e.data  = w;
                e.count = m_count;
                exp_q.push_back(e);
                if (w == HALT || m_addr == TOTAL - 1) m_loading = 1'b0;
                else m_addr++;
            end
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic [7:0] d);
        bus.i_start_load = st;
        bus.i_rx_valid   = v;
        bus.i_rx_data    = d;
        model_step(st, v, d);
        @(posedge clk);
        #1;
        bus.i_start_load = 1'b0;
        bus.i_rx_valid   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_loading = 1'b0;
        m_bytes.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int b = 0; b < 4; b++) begin
            int gap;
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'h00);
            drive(1'b0, 1'b1, w[31-8*b -: 8]);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (bus.o_load_done !== 1'b1 && n < 40) begin
            drive(1'b0, 1'b0, 8'h00);
            n++;
        end
        chk({name, "_done"}, {31'd0, bus.o_load_done}, 32'd1);
        chk({name, "_count"}, bus.o_word_count, m_count);
        chk({name, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
    endtask

    // Monitor: every strobe must match the next predicted write
    always @(negedge clk) begin
        if (bus.o_flag_write_intruc === 1'b1) begin
            chk("strobe_width", {31'd0, strobe_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: addr %h data %h expected no write",
                         bus.o_instruction_address, bus.o_instruction);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", bus.o_instruction_address, e.addr);
                chk("wr_data", bus.o_instruction, e.data);
                chk("wr_count", bus.o_word_count, e.count);
            end
        end
        strobe_prev = bus.o_flag_write_intruc;
    end

    initial begin
        total = 0;
        bad = 0;
        strobe_prev = 1'b0;
        m_loading = 1'b0;
        m_addr = 0;
        m_count = 0;
        bus.i_start_load = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        drive(1'b0, 1'b0, 8'h00);
        chk("rst_instr", bus.o_instruction, 32'd0);
        chk("rst_addr", bus.o_instruction_address, 32'd0);
        chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        chk("rst_done", {31'd0, bus.o_load_done}, 32'd0);
        chk("rst_count", bus.o_word_count, 32'd0);

        // Bytes in IDLE without a start are ignored
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 8'($urandom));
            chk("idle_busy", {31'd0, bus.o_busy}, 32'd0);
        end

        // Basic load with latency checks on the halt word
        drive(1'b1, 1'b0, 8'h00);
        send_word(32'h2008_0005, 1);
        drive(1'b0, 1'b1, 8'hFF);
        drive(1'b0, 1'b1, 8'hFF);
        drive(1'b0, 1'b1, 8'hFF);
        drive(1'b0, 1'b1, 8'hFF);
        chk("lat_n_strobe", {31'd0, bus.o_flag_write_intruc}, 32'd0);
        drive(1'b0, 1'b0, 8'h00);
        chk("lat_n1_strobe", {31'd0, bus.o_flag_write_intruc}, 32'd1);
        chk("lat_n1_done", {31'd0, bus.o_load_done}, 32'd0);
        drive(1'b0, 1'b0, 8'h00);
        chk("lat_n2_strobe", {31'd0, bus.o_flag_write_intruc}, 32'd0);
        chk("lat_n2_done", {31'd0, bus.o_load_done}, 32'd1);
        wait_done("basic");

        // Restart from DONE resets count; then back-to-back bytes
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        chk("restart_count", bus.o_word_count, 32'd0);
        chk("restart_done", {31'd0, bus.o_load_done}, 32'd0);
        chk("restart_busy", {31'd0, bus.o_busy}, 32'd1);
        send_word(32'h1122_3344, 0);
        send_word(32'h5566_7788, 0);
        send_word(32'h99AA_BBCC, 0);
        send_word(HALT, 0);
        wait_done("b2b");

        // Memory full: fifth word must be ignored
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) send_word(32'hA000_0000 + i, 0);
        wait_done("full");

        // Start pulse mid-RECV ignored, then reset mid-word
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'hDE);
        drive(1'b0, 1'b1, 8'hAD);
        drive(1'b1, 1'b1, 8'hBE);
        drive(1'b0, 1'b1, 8'hEF);
        drive(1'b0, 1'b1, 8'h01);
        drive(1'b0, 1'b1, 8'h02);
        do_reset();
        chk("mid_rst_instr", bus.o_instruction, 32'd0);
        chk("mid_rst_count", bus.o_word_count, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.o_busy}, 32'd0);
        drive(1'b1, 1'b0, 8'h00);
        send_word(32'h0BAD_F00D, 1);
        send_word(HALT, 1);
        wait_done("after_rst");

        // Randomized loads with gaps and ignored start pulses
        for (int l = 0; l < 8; l++) begin
            int nw;
            drive(1'b1, 1'b0, 8'h00);
            nw = $urandom_range(1, 5);
            for (int w = 0; w < nw; w++) begin
                logic [31:0] word;
                word = ($urandom_range(0, 4) == 0) ? HALT : 32'($urandom);
                for (int b = 0; b < 4; b++) begin
                    if (m_loading && b > 0 && $urandom_range(0, 5) == 0)
                        drive(1'b1, 1'b0, 8'h00);
                    for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                        drive(1'b0, 1'b0, 8'h00);
                    drive(1'b0, 1'b1, word[31-8*b -: 8]);
                end
            end
            if (m_loading) send_word(HALT, 1);
            wait_done("rand");
        end

        repeat (4) drive(1'b0, 1'b0, 8'h00);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
